// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants, immediate limits and the request payload shared by
// the instruction encoder/writer and its field packer.
package rv_isa_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'b00,
    FMT_I = 2'b01,
    FMT_S = 2'b10,
    FMT_B = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FULL = 2'b10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam int unsigned INST_W = 32;

  // 12-bit I/S immediate and 13-bit (even) branch offset
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } inst_req_t;

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational fields-to-word encoder for R/I/S/B formats with an
// immediate legality flag.
module inst_pack
  import rv_isa_pkg::*;
(
  input  inst_req_t           req,
  output logic [INST_W-1:0]   word_c,
  output logic                imm_ok_c
);

  always_comb begin
    word_c   = '0;
    imm_ok_c = 1'b1;
    case (req.fmt)
      FMT_R: begin
        word_c = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      end
      FMT_I: begin
        word_c   = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        imm_ok_c = imm_in_range(req.imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        word_c   = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
        imm_ok_c = imm_in_range(req.imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        word_c   = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                    req.imm[4:1], req.imm[11], req.opcode};
        // branch offsets are halfword-aligned; an odd offset is unencodable
        imm_ok_c = imm_in_range(req.imm, IMM13_MIN, IMM13_MAX) && !req.imm[0];
      end
      default: begin
        word_c   = '0;
        imm_ok_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder_writer.sv
// Encodes decoded instruction fields and streams the words into instruction
// memory through a single held output register.
module inst_encoder_writer
  import rv_isa_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_wr_en,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_imm
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("DEPTH must be a power of two and at least 2");
  end
  if ((64'd1 << ADDR_W) < 64'(4 * DEPTH)) begin : g_addr_chk
    $error("ADDR_W too narrow to byte-address DEPTH words");
  end

  state_e            state;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  wr_cnt_nxt;
  inst_req_t         req;
  logic [INST_W-1:0] word;
  logic              imm_ok;
  logic              accept;
  logic              wr_fire;

  assign req = '{
    fmt:    fmt_e'(in_fmt),
    opcode: in_opcode,
    rd:     in_rd,
    rs1:    in_rs1,
    rs2:    in_rs2,
    funct3: in_funct3,
    funct7: in_funct7,
    imm:    in_imm
  };

  inst_pack u_pack (
    .req      (req),
    .word_c   (word),
    .imm_ok_c (imm_ok)
  );

  // The output register may take a new word in the same cycle the old one drains.
  assign in_ready   = (state == ST_RUN) && !start && (issue_cnt < CNT_W'(DEPTH)) &&
                      (!mem_wr_en || mem_ready);
  assign accept     = in_valid && in_ready;
  assign wr_fire    = mem_wr_en && mem_ready;
  assign wr_cnt_nxt = wr_cnt + CNT_W'(wr_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      wr_cnt    <= '0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_imm   <= 1'b0;
    end else if (start) begin
      // restart from any state, flushing a word still waiting on memory
      state     <= ST_RUN;
      issue_cnt <= '0;
      wr_cnt    <= '0;
      mem_wr_en <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      err_imm   <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_cnt    <= wr_cnt_nxt;
        mem_wr_en <= 1'b0;
      end
      if (accept) begin
        if (imm_ok) begin
          mem_wr_en <= 1'b1;
          mem_addr  <= ADDR_W'(issue_cnt) << 2;
          mem_wdata <= word;
          issue_cnt <= issue_cnt + CNT_W'(1);
        end else begin
          err_imm   <= 1'b1;
        end
      end
      if ((state == ST_RUN) && (wr_cnt_nxt == CNT_W'(DEPTH))) begin
        state <= ST_FULL;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder_writer.sv
// Directed bench for inst_encoder_writer: hand-computed encodings, range
// errors, backpressure, full-depth streaming, start flush and reset.
module tb_inst_encoder_writer;
  import rv_isa_pkg::*;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              mem_wr_en;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err_imm;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];

  inst_encoder_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .mem_wr_en (mem_wr_en),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err_imm   (err_imm)
  );

  always #5 clk = ~clk;

  // memory model: records every completed write handshake
  always @(posedge clk) begin
    if (!rst && mem_wr_en && mem_ready) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Present a request from a negedge until accepted; returns at posedge+1.
  task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic exp_wr);
    bit acc = 1'b0;
    @(negedge clk);
    set_req(f, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (in_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    tests++;
    if (!acc) begin
      fails++;
      $error("FAIL send_timeout observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc) check("accept_latency_wr_en", 32'(mem_wr_en), 32'(exp_wr));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    check({tag, "_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_wdata"}, mem_wdata,      32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_err"},   32'(err_imm),   32'd0);
    check({tag, "_ready"}, 32'(in_ready),  32'd0);
  endtask

  function automatic logic [31:0] enc_r(input int i);
    logic [4:0] rd  = 5'(i + 2);
    logic [4:0] rs1 = 5'(i + 1);
    logic [4:0] rs2 = 5'(i);
    return {7'b0100000, rs2, rs1, 3'b000, rd, OP_OP};
  endfunction

  initial begin
    int sent;
    int cycles;
    bit acc;
    bit addr_ok;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    set_req(2'b00, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

    // 1: reset state, then I-format load with negative immediate
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    send(FMT_I, OP_LOAD, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, -32'sd4, 1'b1);
    check("t1_wdata_held", mem_wdata, 32'hFFC12283);
    idle_cycles(3);
    check("t1_count", 32'(log_addr.size()), 32'd1);
    check("t1_addr", 32'(log_addr[0]), 32'd0);
    check("t1_data", log_data[0], 32'hFFC12283);

    // 2: store then backward branch
    pulse_start();
    send(FMT_S, OP_STORE, 5'd0, 5'd1, 5'd3, 3'b010, 7'd0, 32'd8, 1'b1);
    send(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd8, 1'b1);
    idle_cycles(3);
    check("t2_count", 32'(log_addr.size()), 32'd2);
    check("t2_addr0", 32'(log_addr[0]), 32'd0);
    check("t2_data0", log_data[0], 32'h0030A423);
    check("t2_addr1", 32'(log_addr[1]), 32'd4);
    check("t2_data1", log_data[1], 32'hFE208CE3);
    check("t2_err", 32'(err_imm), 32'd0);

    // 3: immediate range and alignment errors
    pulse_start();
    send(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 1'b0);
    check("t3_err_after_i", 32'(err_imm), 32'd1);
    send(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd6, 1'b1);
    send(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd5, 1'b0);
    idle_cycles(3);
    check("t3_count", 32'(log_addr.size()), 32'd1);
    check("t3_addr", 32'(log_addr[0]), 32'd0);
    check("t3_data", log_data[0], 32'h00208363);
    check("t3_err_sticky", 32'(err_imm), 32'd1);
    pulse_start();
    check("t3_err_cleared", 32'(err_imm), 32'd0);

    // 4: memory backpressure with a second request waiting
    mem_ready = 1'b0;
    send(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 1'b1);
    set_req(FMT_I, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("t4_stall_ready", 32'(in_ready), 32'd0);
      check("t4_stall_wr_en", 32'(mem_wr_en), 32'd1);
      check("t4_stall_addr", 32'(mem_addr), 32'd0);
      check("t4_stall_wdata", mem_wdata, 32'h00100093);
    end
    mem_ready = 1'b1;
    #1;
    check("t4_ready_on_drain", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("t4_next_addr", 32'(mem_addr), 32'd4);
    check("t4_next_wdata", mem_wdata, 32'h00200113);
    idle_cycles(3);
    check("t4_count", 32'(log_addr.size()), 32'd2);
    check("t4_log_addr0", 32'(log_addr[0]), 32'd0);
    check("t4_log_data0", log_data[0], 32'h00100093);
    check("t4_log_addr1", 32'(log_addr[1]), 32'd4);
    check("t4_log_data1", log_data[1], 32'h00200113);

    // 5: fill the whole memory back-to-back
    pulse_start();
    sent = 0;
    cycles = 0;
    @(negedge clk);
    set_req(FMT_R, OP_OP, 5'(sent + 2), 5'(sent + 1), 5'(sent), 3'b000, 7'b0100000, 32'hDEAD_BEEF);
    in_valid = 1'b1;
    while (sent < int'(DEPTH) && cycles < 300) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
      cycles++;
      if (acc) sent++;
      set_req(FMT_R, OP_OP, 5'(sent + 2), 5'(sent + 1), 5'(sent), 3'b000, 7'b0100000, 32'hDEAD_BEEF);
      @(negedge clk);
    end
    check("t5_sent", 32'(sent), 32'(DEPTH));
    check("t5_cycles", 32'(cycles), 32'(DEPTH));
    idle_cycles(3);
    #1;
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    check("t5_count", 32'(log_addr.size()), 32'(DEPTH));
    addr_ok = 1'b1;
    for (int i = 0; i < log_addr.size(); i++) begin
      if (32'(log_addr[i]) != 32'(4 * i) || log_data[i] !== enc_r(i)) addr_ok = 1'b0;
    end
    check("t5_stream_contents", 32'(addr_ok), 32'd1);
    check("t5_last_data", log_data[DEPTH-1], enc_r(int'(DEPTH) - 1));

    // 6: start flushes a pending word and wins over a same-cycle request
    pulse_start();
    check("t6_done_cleared", 32'(done), 32'd0);
    mem_ready = 1'b0;
    send(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 1'b1);
    @(negedge clk);
    start = 1'b1;
    set_req(FMT_I, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2);
    in_valid = 1'b1;
    #1;
    check("t6_ready_during_start", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    log_addr.delete();
    log_data.delete();
    check("t6_flushed_wr_en", 32'(mem_wr_en), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("t6_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("t6_addr", 32'(mem_addr), 32'd0);
    check("t6_wdata", mem_wdata, 32'h00200113);
    idle_cycles(2);
    check("t6_count", 32'(log_addr.size()), 32'd1);
    check("t6_log_data", log_data[0], 32'h00200113);

    // reset with a word pending
    mem_ready = 1'b0;
    send(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 1'b1);
    check("t6_pending_addr", 32'(mem_addr), 32'd4);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    idle_cycles(2);
    check("t6_no_write_after_rst", 32'(log_addr.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
